usart_rx: RTL and testbench

//  UART receive side of the logic-analyzer host link; pairs with the on-chip UART transmitter.

---
 rtl/usart_rx.sv | 136 +++++++++++++
 tb/tb_usart_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/usart_rx.sv
// 8N1 UART receiver, clk at 4x baud; majority-voted bits, one-byte holding register
// with sticky framing and overrun flags.
//  state   | meaning
//  S_IDLE  | waiting for a falling edge on the synchronised line
//  S_START | checking the start bit, glitches rejected at phase 3
//  S_DATA  | shifting in 8 data bits, LSB first
//  S_STOP  | checking the stop bit, exits at phase 2 to leave resync margin
module usart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  input  logic       i_read,
  output logic [7:0] o_rxdata,
  output logic       o_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_q;
  logic [1:0]             r_phase;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_s1;
  logic                   r_s2;
  logic [7:0]             r_rxdata;
  logic                   r_ready;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   r_busy;

  logic w_rx_s;
  logic w_edge;
  logic w_maj;
  logic w_stop_ok;

  assign w_rx_s    = r_sync[SYNC_STAGES-1];
  assign w_edge    = r_rx_q & ~w_rx_s;
  // r_s1/r_s2 hold the phase-1 and phase-2 samples; the phase-3 sample is taken live
  assign w_maj     = (r_s1 & r_s2) | (r_s1 & w_rx_s) | (r_s2 & w_rx_s);
  assign w_stop_ok = r_s1 & w_rx_s;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_sync <= '1;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rx_q      <= 1'b1;
      r_phase     <= 2'd0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_s1        <= 1'b1;
      r_s2        <= 1'b1;
      r_rxdata    <= 8'h00;
      r_ready     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_q <= w_rx_s;
      if (r_phase == 2'd1) r_s1 <= w_rx_s;
      if (r_phase == 2'd2) r_s2 <= w_rx_s;
      if (i_read) begin
        r_ready     <= 1'b0;
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_phase <= 2'd0;
          if (w_edge) begin
            r_state <= S_START;
            r_phase <= 2'd1;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          r_phase <= r_phase + 2'd1;
          if (r_phase == 2'd3) begin
            if (w_maj) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd0;
            end
          end
        end
        S_DATA: begin
          r_phase <= r_phase + 2'd1;
          if (r_phase == 2'd3) begin
            r_shift   <= {w_maj, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          r_phase <= r_phase + 2'd1;
          if (r_phase == 2'd2) begin
            r_state <= S_IDLE;
            r_phase <= 2'd0;
            r_busy  <= 1'b0;
            // completion overrides a same-cycle read of the previous byte
            if (w_stop_ok) begin
              r_rxdata <= r_shift;
              r_ready  <= 1'b1;
              if (r_ready && !i_read) r_overrun <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rxdata    = r_rxdata;
  assign o_ready     = r_ready;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_usart_rx.sv
// Scoreboard bench for usart_rx: directed scenarios then random frames, checked against
// a byte-level model of the holding register and flags.
module tb_usart_rx;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       read;
  logic [7:0] rxdata;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  usart_rx #(.SYNC_STAGES(SYNC)) dut (
    .i_clk(clk), .i_reset(reset), .i_rx(rx), .i_read(read),
    .o_rxdata(rxdata), .o_ready(ready), .o_frame_err(frame_err),
    .o_overrun(overrun), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind 0: frame end seen as busy falling; kind 1: read acknowledged
  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] data;
    logic       rdy;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_data;
  logic       m_rdy, m_fe, m_ov;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input int c);
    exp_t e;
    e.kind = kind; e.cyc = c; e.data = m_data; e.rdy = m_rdy; e.fe = m_fe; e.ov = m_ov;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit do_read,
                            input int gl_bit, input int gap);
    int   st, k, goff;
    logic bitv;
    st   = cyc;
    goff = $urandom_range(1, 3);
    if (do_read) begin
      m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      push_exp(1, st + 9);
    end
    if (stop_bit) begin
      if (m_rdy) m_ov = 1'b1;
      m_data = b;
      m_rdy  = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
    push_exp(0, st + SYNC + 39);
    for (int j = 0; j < 40; j++) begin
      k = j / 4;
      if (k == 0)      bitv = 1'b0;
      else if (k == 9) bitv = stop_bit;
      else             bitv = b[k-1];
      if (k - 1 == gl_bit && j % 4 == goff) bitv = ~bitv;
      rx   = bitv;
      read = do_read && (j == 8);
      @(negedge clk);
    end
    read = 1'b0;
    rx   = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_glitch();
    push_exp(0, cyc + SYNC + 4);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: kind %0d with nothing expected (cycle %0d)", kind, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("rxdata", rxdata, e.data);
      chk("ready", ready, e.rdy);
      chk("frame_err", frame_err, e.fe);
      chk("overrun", overrun, e.ov);
    end
  endtask

  initial begin : monitor
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        chk("rst_rxdata", rxdata, 8'h00);
        chk("rst_ready", ready, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !busy) pop_check(0);
        if (read) pop_check(1);
        prev_busy = busy;
      end
    end
  end

  initial begin : driver
    int   b, stp, rd, gl, gp;
    logic [7:0] pb;
    reset = 1'b1; rx = 1'b1; read = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b0, -1, 8);
    send_frame(8'h00, 1'b1, 1'b1, -1, 0);
    send_frame(8'hFF, 1'b1, 1'b1, -1, 0);
    send_frame(8'h3C, 1'b1, 1'b1, -1, 8);
    send_frame(8'hC3, 1'b1, 1'b0, -1, 8);
    send_frame(8'h55, 1'b0, 1'b1, -1, 0);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);

    send_glitch();
    send_frame(8'h81, 1'b1, 1'b1, 3, 8);

    pb = 8'h5A;
    for (int j = 0; j < 22; j++) begin
      rx = (j < 4) ? 1'b0 : pb[j/4 - 1];
      @(negedge clk);
    end
    rx = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    send_frame(8'h12, 1'b1, 1'b0, -1, 8);

    for (int n = 0; n < 30; n++) begin
      b   = $urandom_range(0, 255);
      stp = ($urandom_range(0, 5) != 0) ? 1 : 0;
      rd  = $urandom_range(0, 1);
      gl  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1;
      gp  = stp ? $urandom_range(0, 6) : $urandom_range(2, 6);
      if (n % 10 == 9) send_glitch();
      send_frame(b[7:0], stp[0], rd[0], gl, gp);
    end

    for (int t = 0; t < 200 && q.size() > 0; t++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
